model_loader: RTL and testbench
===============================

MODEL_LOADER -- requirements
Module: model_loader

Interface
REQ-001 The block SHALL have parameter NUM_FEATURES_IN, default 16: features per vector; coefficients per support vector = NUM_FEATURES_IN-1.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles between input bytes inside a frame.
REQ-003 The block SHALL have parameter SOF_BYTE, default 8'hA5: start-of-frame marker.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port ble_data_in, input, 8 bits: received BLE/UART byte.
REQ-007 The block SHALL have port ble_valid_in, input, 1 bit: ble_data_in valid for one cycle; upstream guarantees valids are at least 2 cycles apart.
REQ-008 The block SHALL have port cfg_data_out, output, 8 bits: byte forwarded to the classifier model port.
REQ-009 The block SHALL have port cfg_valid_out, output, 1 bit: cfg_data_out valid for one cycle.
REQ-010 The block SHALL have port predict_request_in, input, 1 bit: system request to run prediction.
REQ-011 The block SHALL have port predict_enable_out, output, 1 bit: gated prediction enable to the classifier.
REQ-012 The block SHALL have port model_ready_out, output, 1 bit: a complete, checksum-valid model is loaded.
REQ-013 The block SHALL have port busy_out, output, 1 bit: a frame is in progress.
REQ-014 The block SHALL have port load_error_out, output, 1 bit: sticky flag, last frame failed.

Function
REQ-015 Frame format SHALL be SOF_BYTE, count N (1..255), P = N*(NUM_FEATURES_IN-1)*2+4 payload bytes (coefficients then 4 offset bytes, MSB first), then a check byte equal to the XOR of N and all P payload bytes.
REQ-016 The FSM SHALL have states IDLE, COUNT, PAYLOAD, CHECK and FLUSH.
REQ-017 In IDLE, a valid byte equal to SOF_BYTE SHALL move the FSM to COUNT and set busy_out=1, model_ready_out=0 and load_error_out=0 on the next cycle; any other byte SHALL be dropped with no flag change.
REQ-018 In COUNT, N=0 SHALL not be forwarded and SHALL set load_error_out and return to IDLE; N>0 SHALL be forwarded, seed the XOR accumulator with N, load a 16-bit remaining counter with P, and move to PAYLOAD.
REQ-019 In PAYLOAD, each valid byte SHALL be forwarded, XORed into the accumulator, and decrement the remaining counter; when the counter reaches 0 the FSM SHALL move to CHECK.
REQ-020 SOF_BYTE values inside COUNT or PAYLOAD SHALL be treated as data.
REQ-021 In CHECK, the valid byte SHALL not be forwarded; on a match model_ready_out SHALL go to 1, otherwise load_error_out SHALL go to 1; the FSM SHALL then return to IDLE with busy_out=0.
REQ-022 Forwarding SHALL be registered: cfg_valid_out and cfg_data_out SHALL appear exactly 1 cycle after the accepting ble_valid_in.
REQ-023 A timeout counter SHALL clear on each accepted byte and on entry to COUNT, and SHALL count only in COUNT, PAYLOAD and CHECK.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES: in COUNT or CHECK the block SHALL set load_error_out and go to IDLE; in PAYLOAD it SHALL go to FLUSH.
REQ-025 FLUSH SHALL emit the remaining payload bytes as 8'h00, one every 2 cycles, ignore ble_valid_in, then set load_error_out and go to IDLE, so the classifier always receives exactly 1+P bytes.
REQ-026 predict_enable_out SHALL be registered as predict_request_in AND model_ready_out AND NOT busy_out.
REQ-027 A frame SHALL never be aborted by a new SOF; only timeout or reset aborts a frame.

Reset
REQ-028 While rst_in=1, the block SHALL go to IDLE and drive cfg_valid_out=0, cfg_data_out=0, predict_enable_out=0, model_ready_out=0, busy_out=0 and load_error_out=0, with counters and the accumulator cleared.
REQ-029 Reset mid-frame SHALL discard the frame with no flush; the classifier shares rst_in.

Verification (NUM_FEATURES_IN=4, TIMEOUT_CYCLES=100, so N=2 gives P=16)
REQ-030 Good load: A5, 02, bytes 01..10, check = 02^01^..^10 = 0x12 -> 17 bytes forwarded (02,01..10) each 1 cycle late; model_ready_out=1; load_error_out=0; busy_out=0.
REQ-031 Bad checksum: same frame with check 0x13 -> 17 bytes forwarded; model_ready_out=0; load_error_out=1; predict_enable_out stays 0 with predict_request_in=1.
REQ-032 Zero count: A5, 00 -> no cfg_valid_out pulses; load_error_out=1; FSM back in IDLE, so a following good frame loads successfully.
REQ-033 Timeout: A5, 02, 5 payload bytes, then silence -> after 100 cycles, 11 bytes of 00 emitted 2 cycles apart; then load_error_out=1 and busy_out=0.
REQ-034 Gating and garbage: after a good load, send 3C, 77 with predict_request_in=1 -> no forwarding; predict_enable_out=1; then A5 -> predict_enable_out=0 within 2 cycles.
REQ-035 Reset mid-PAYLOAD -> all outputs 0 the next cycle; a subsequent good frame loads correctly.

Source files
------------

// File: rtl/model_loader.sv
// model_loader: receives a framed classifier model over a byte stream
// (BLE/UART), forwards the count and payload bytes to the classifier model
// port, verifies an XOR check byte and gates prediction requests until a
// valid model is loaded.
//
// Frame: SOF_BYTE, N (1..255), P = N*(NUM_FEATURES_IN-1)*2+4 payload bytes,
// check byte = N ^ payload[0] ^ ... ^ payload[P-1].
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   ble_data_in/valid_in  received byte stream (valids >= 2 cycles apart)
//   cfg_data_out/valid_out forwarded byte to the classifier, 1 cycle latency
//   predict_request_in    system request to run a prediction
//   predict_enable_out    request gated by model_ready and not busy
//   model_ready_out       a checksum-valid model is loaded
//   busy_out              a frame is in progress
//   load_error_out        sticky: last frame failed
module model_loader #(
    parameter int unsigned NUM_FEATURES_IN = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter logic [7:0]  SOF_BYTE        = 8'hA5
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] ble_data_in,
    input  logic       ble_valid_in,
    output logic [7:0] cfg_data_out,
    output logic       cfg_valid_out,
    input  logic       predict_request_in,
    output logic       predict_enable_out,
    output logic       model_ready_out,
    output logic       busy_out,
    output logic       load_error_out
);

    localparam logic [15:0] COEF_BYTES = 16'(2 * (NUM_FEATURES_IN - 1));
    localparam int unsigned TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StPayload,
        StCheck,
        StFlush
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        rem_q, rem_d;
    logic [7:0]         acc_q, acc_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               flush_wait_q, flush_wait_d;
    logic [7:0]         cfg_data_q, cfg_data_d;
    logic               cfg_valid_q, cfg_valid_d;
    logic               ready_q, ready_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;
    logic               pred_en_q, pred_en_d;

    logic               timed_out;
    logic [15:0]        payload_len;

    assign timed_out   = (timer_q == TIMER_LAST);
    assign payload_len = 16'(ble_data_in) * COEF_BYTES + 16'd4;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        acc_d        = acc_q;
        timer_d      = timer_q;
        flush_wait_d = flush_wait_q;
        cfg_data_d   = cfg_data_q;
        cfg_valid_d  = 1'b0;
        ready_d      = ready_q;
        error_d      = error_q;

        unique case (state_q)
            StIdle: begin
                // Keeping the timer clear here gives a clean start in COUNT.
                timer_d = '0;
                if (ble_valid_in && (ble_data_in == SOF_BYTE)) begin
                    state_d = StCount;
                    ready_d = 1'b0;
                    error_d = 1'b0;
                end
            end
            StCount: begin
                if (ble_valid_in) begin
                    timer_d = '0;
                    if (ble_data_in == 8'h00) begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cfg_valid_d = 1'b1;
                        cfg_data_d  = ble_data_in;
                        acc_d       = ble_data_in;
                        rem_d       = payload_len;
                        state_d     = StPayload;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StPayload: begin
                if (ble_valid_in) begin
                    timer_d     = '0;
                    cfg_valid_d = 1'b1;
                    cfg_data_d  = ble_data_in;
                    acc_d       = acc_q ^ ble_data_in;
                    rem_d       = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = StCheck;
                    end
                end else if (timed_out) begin
                    // Pad the classifier up to a full frame before giving up.
                    flush_wait_d = 1'b0;
                    state_d      = StFlush;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StCheck: begin
                if (ble_valid_in) begin
                    timer_d = '0;
                    if (ble_data_in == acc_q) begin
                        ready_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = StIdle;
                end else if (timed_out) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StFlush: begin
                timer_d = '0;
                if (flush_wait_q) begin
                    flush_wait_d = 1'b0;
                end else if (rem_q == 16'd0) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cfg_valid_d  = 1'b1;
                    cfg_data_d   = 8'h00;
                    rem_d        = rem_q - 16'd1;
                    flush_wait_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d    = (state_d != StIdle);
        pred_en_d = predict_request_in & ready_q & ~busy_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            rem_q        <= '0;
            acc_q        <= '0;
            timer_q      <= '0;
            flush_wait_q <= 1'b0;
            cfg_data_q   <= '0;
            cfg_valid_q  <= 1'b0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            pred_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            acc_q        <= acc_d;
            timer_q      <= timer_d;
            flush_wait_q <= flush_wait_d;
            cfg_data_q   <= cfg_data_d;
            cfg_valid_q  <= cfg_valid_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            pred_en_q    <= pred_en_d;
        end
    end

    assign cfg_data_out       = cfg_data_q;
    assign cfg_valid_out      = cfg_valid_q;
    assign model_ready_out    = ready_q;
    assign load_error_out     = error_q;
    assign busy_out           = busy_q;
    assign predict_enable_out = pred_en_q;

endmodule

// File: tb/tb_model_loader.sv
// Testbench for model_loader: frame-level reference model. Each sent byte
// records the cycle its forwarded copy must appear; a per-cycle compare
// process checks cfg_valid_out/cfg_data_out against that schedule, and the
// frame driver checks flags after each frame.
module tb_model_loader;

    localparam int unsigned NF  = 4;
    localparam int unsigned TO  = 100;
    localparam logic [7:0]  SOF = 8'hA5;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] ble_data_in = 8'h00;
    logic       ble_valid_in = 1'b0;
    logic [7:0] cfg_data_out;
    logic       cfg_valid_out;
    logic       predict_request_in = 1'b0;
    logic       predict_enable_out;
    logic       model_ready_out;
    logic       busy_out;
    logic       load_error_out;

    always #5 clk_in = ~clk_in;

    model_loader #(
        .NUM_FEATURES_IN(NF),
        .TIMEOUT_CYCLES (TO),
        .SOF_BYTE       (SOF)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .ble_data_in       (ble_data_in),
        .ble_valid_in      (ble_valid_in),
        .cfg_data_out      (cfg_data_out),
        .cfg_valid_out     (cfg_valid_out),
        .predict_request_in(predict_request_in),
        .predict_enable_out(predict_enable_out),
        .model_ready_out   (model_ready_out),
        .busy_out          (busy_out),
        .load_error_out    (load_error_out)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int fwd_count = 0;
    logic [7:0] exp_fwd [int];  // cycle -> byte that must be on cfg_data_out
    logic [7:0] pay [$];

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(negedge clk_in) begin
        if (exp_fwd.exists(cyc)) begin
            check("cfg_valid", {31'b0, cfg_valid_out}, 32'd1);
            check("cfg_data", {24'b0, cfg_data_out}, {24'b0, exp_fwd[cyc]});
            exp_fwd.delete(cyc);
        end else begin
            check("cfg_valid_idle", {31'b0, cfg_valid_out}, 32'd0);
        end
        if (cfg_valid_out === 1'b1) fwd_count++;
    end

    function automatic int plen(input int n);
        return n * (int'(NF) - 1) * 2 + 4;
    endfunction

    function automatic logic [7:0] frame_check(input int n, input int p);
        logic [7:0] x;
        x = 8'(n);
        for (int i = 0; i < p; i++) x ^= pay[i];
        return x;
    endfunction

    task automatic gap(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit fwd, output int t);
        @(negedge clk_in);
        ble_data_in  = b;
        ble_valid_in = 1'b1;
        t = cyc;
        if (fwd) exp_fwd[cyc + 1] = b;
        @(negedge clk_in);
        ble_valid_in = 1'b0;
    endtask

    task automatic fill_seq(input int p);
        pay.delete();
        for (int i = 0; i < p; i++) pay.push_back(8'(i + 1));
    endtask

    task automatic fill_random(input int p);
        logic [7:0] b;
        pay.delete();
        for (int i = 0; i < p; i++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) b = SOF;
            pay.push_back(b);
        end
    endtask

    task automatic check_flags(input string name, input bit ready, input bit err,
                               input bit busy);
        check({name, ".ready"}, {31'b0, model_ready_out}, {31'b0, ready});
        check({name, ".error"}, {31'b0, load_error_out}, {31'b0, err});
        check({name, ".busy"}, {31'b0, busy_out}, {31'b0, busy});
    endtask

    // sent < 0: full frame with check byte; otherwise deliver 'sent' payload
    // bytes, then go silent and expect the timeout path.
    task automatic send_frame(input string name, input int n, input bit corrupt,
                              input int sent, input bit with_sof);
        int t, p, r, start, target;
        logic [7:0] chk;
        p = plen(n);
        if (with_sof) begin
            drive_byte(SOF, 1'b0, t);
            check_flags({name, ".sof"}, 1'b0, 1'b0, 1'b1);
        end
        start = fwd_count;
        gap($urandom_range(0, 3));
        drive_byte(8'(n), n != 0, t);
        if (n == 0) begin
            gap(2);
            check_flags({name, ".zero"}, 1'b0, 1'b1, 1'b0);
            check({name, ".zero_fwd"}, fwd_count - start, 32'd0);
            return;
        end
        r = (sent < 0) ? p : sent;
        for (int i = 0; i < r; i++) begin
            gap($urandom_range(0, 3));
            drive_byte(pay[i], 1'b1, t);
        end
        if (sent < 0) begin
            chk = frame_check(n, p) ^ {7'b0, corrupt};
            gap($urandom_range(0, 3));
            drive_byte(chk, 1'b0, t);
            gap(2);
            check_flags({name, ".done"}, !corrupt, corrupt, 1'b0);
        end else begin
            for (int k = 0; k < p - r; k++) exp_fwd[t + int'(TO) + 2 + 2 * k] = 8'h00;
            target = t + int'(TO);
            while (cyc < target) @(negedge clk_in);
            check({name, ".busy_before_to"}, {31'b0, busy_out}, 32'd1);
            target = t + int'(TO) + 3 + 2 * (p - r);
            while (cyc < target) @(negedge clk_in);
            check_flags({name, ".timeout"}, 1'b0, 1'b1, 1'b0);
        end
        check({name, ".fwd_total"}, fwd_count - start, 1 + p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c0, n, mode;
        logic [7:0] b;

        // Reset state
        gap(3);
        check("rst.cfg_valid", {31'b0, cfg_valid_out}, 32'd0);
        check("rst.cfg_data", {24'b0, cfg_data_out}, 32'd0);
        check("rst.pred_en", {31'b0, predict_enable_out}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        rst_in = 1'b0;
        gap(2);

        // Pin the model against hand-computed values
        fill_seq(16);
        check("lit.plen2", plen(2), 32'd16);
        check("lit.chk", {24'b0, frame_check(2, 16)}, 32'h12);

        // Good load, then prediction gating opens
        c0 = fwd_count;
        send_frame("good", 2, 1'b0, -1, 1'b1);
        check("good.fwd17", fwd_count - c0, 32'd17);
        predict_request_in = 1'b1;
        gap(2);
        check("good.pred_en", {31'b0, predict_enable_out}, 32'd1);
        predict_request_in = 1'b0;
        gap(2);
        check("good.pred_off", {31'b0, predict_enable_out}, 32'd0);

        // Bad checksum with prediction requested
        predict_request_in = 1'b1;
        fill_seq(16);
        send_frame("badchk", 2, 1'b1, -1, 1'b1);
        gap(2);
        check("badchk.pred_en", {31'b0, predict_enable_out}, 32'd0);
        predict_request_in = 1'b0;

        // Zero count, then a good frame still loads
        send_frame("zero", 0, 1'b0, -1, 1'b1);
        fill_random(16);
        send_frame("after_zero", 2, 1'b0, -1, 1'b1);

        // Garbage in IDLE is dropped; SOF closes the prediction gate
        predict_request_in = 1'b1;
        drive_byte(8'h3C, 1'b0, t);
        gap(1);
        drive_byte(8'h77, 1'b0, t);
        gap(2);
        check("garbage.pred_en", {31'b0, predict_enable_out}, 32'd1);
        check_flags("garbage", 1'b1, 1'b0, 1'b0);
        drive_byte(SOF, 1'b0, t);
        gap(1);
        check("sof.pred_off", {31'b0, predict_enable_out}, 32'd0);
        predict_request_in = 1'b0;
        fill_random(16);
        send_frame("gate_frame", 2, 1'b0, -1, 1'b0);

        // Timeout in PAYLOAD: 11 zero bytes flushed
        fill_random(16);
        c0 = fwd_count;
        send_frame("to_payload", 2, 1'b0, 5, 1'b1);
        check("to_payload.fwd17", fwd_count - c0, 32'd17);

        // Timeout in CHECK: no flush
        fill_random(plen(1));
        send_frame("to_check", 1, 1'b0, plen(1), 1'b1);

        // Reset mid-PAYLOAD discards the frame with no flush
        fill_random(16);
        drive_byte(SOF, 1'b0, t);
        drive_byte(8'h02, 1'b1, t);
        for (int i = 0; i < 5; i++) drive_byte(pay[i], 1'b1, t);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("midrst.cfg_valid", {31'b0, cfg_valid_out}, 32'd0);
        check("midrst.cfg_data", {24'b0, cfg_data_out}, 32'd0);
        check("midrst.pred_en", {31'b0, predict_enable_out}, 32'd0);
        check_flags("midrst", 1'b0, 1'b0, 1'b0);
        gap(int'(TO) + 30);
        fill_random(16);
        send_frame("after_rst", 2, 1'b0, -1, 1'b1);

        // Count equal to SOF is data
        fill_random(plen(165));
        send_frame("n_sof", 165, 1'b0, -1, 1'b1);

        // Randomized frames with IDLE garbage in between
        for (int it = 0; it < 8; it++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SOF) b = 8'h00;
                drive_byte(b, 1'b0, t);
            end
            n = int'($urandom_range(1, 3));
            mode = int'($urandom_range(0, 2));
            fill_random(plen(n));
            if (mode == 2) send_frame("rnd_to", n, 1'b0, int'($urandom_range(0, plen(n) - 1)), 1'b1);
            else send_frame("rnd", n, mode == 1, -1, 1'b1);
        end

        gap(5);
        check("end.pending", exp_fwd.num(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
